lcd_text_writer: RTL and testbench

Avalon-MM master that sits directly upstream of the character-LCD controller (the 2x16 HD44780 Avalon slave). Holds a 32-character screen buffer written by the application logic, runs the LCD power-on command sequence once after reset, and redraws the full screen whenever the buffer changes or a refresh is requested. All LCD pacing comes from the slave's `waitrequest`, plus a fixed post-clear delay.

---
 rtl/lcd_text_pkg.sv | 35 +++
 rtl/lcd_char_buffer.sv | 31 +++
 rtl/lcd_text_writer.sv | 156 +++++++++++++++
 tb/tb_lcd_text_writer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_text_pkg.sv
// Shared constants and types for the character-LCD text writer.
// Contents: HD44780 instruction bytes, screen geometry, the writer FSM
// state type, and a helper that maps an init step to its instruction.
package lcd_text_pkg;

  localparam int SCREEN_CHARS = 32;
  localparam int LINE_CHARS   = 16;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE0    = 8'h80;
  localparam logic [7:0] CMD_LINE1    = 8'hC0;
  localparam logic [7:0] CHAR_SPACE   = 8'h20;

  typedef enum logic [2:0] {
    ST_INIT_CMD  = 3'd0,
    ST_CLR_WAIT  = 3'd1,
    ST_IDLE      = 3'd2,
    ST_LINE_ADDR = 3'd3,
    ST_CHAR_WR   = 3'd4,
    ST_GAP       = 3'd5
  } lcd_state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_char_buffer.sv
// 32x8 screen buffer: one synchronous write port, one combinational read
// port. Filled with spaces while reset is low.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   wr_en/addr/data   write port
//   rd_addr/rd_data   combinational read port
module lcd_char_buffer
  import lcd_text_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [SCREEN_CHARS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SCREEN_CHARS; i++) mem[i] <= CHAR_SPACE;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_text_writer.sv
// Avalon-MM master feeding a 2x16 HD44780 character-LCD slave.
// Runs the power-on instruction sequence once after reset, then redraws
// the whole screen (line address + 16 chars, twice) whenever the screen
// buffer is written or a refresh is requested.
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   char_valid/ready/pos/data       buffer write handshake
//   refresh                         full-redraw request
//   busy                            init/redraw active or pending
//   lcd_address/chipselect/write/
//   lcd_read/writedata/waitrequest  Avalon master to the LCD slave
module lcd_text_writer
  import lcd_text_pkg::*;
#(
  parameter int CLEAR_WAIT_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [4:0] char_pos,
  input  logic [7:0] char_data,
  input  logic       refresh,
  output logic       busy,
  output logic       lcd_address,
  output logic       lcd_chipselect,
  output logic       lcd_write,
  output logic       lcd_read,
  output logic [7:0] lcd_writedata,
  input  logic       lcd_waitrequest
);

  localparam int WAIT_W = $clog2(CLEAR_WAIT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CLEAR_WAIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  lcd_state_t        state;
  lcd_state_t        ret_state;
  logic [1:0]        step;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        col;
  logic              line;
  logic              dirty;
  logic [7:0]        char_q;
  logic [7:0]        rd_data;
  logic [7:0]        xfer_data;
  logic              wr_en;
  logic              in_xfer;

  // Writes are accepted in every cycle once reset is released, so ready
  // simply follows reset.
  assign char_ready = reset;
  assign wr_en      = char_valid && char_ready;

  lcd_char_buffer u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (char_pos),
    .wr_data (char_data),
    .rd_addr ({line, col}),
    .rd_data (rd_data)
  );

  assign in_xfer = (state == ST_INIT_CMD) || (state == ST_LINE_ADDR) ||
                   (state == ST_CHAR_WR);

  // Every transfer is followed by one GAP cycle; ret_state records where
  // to go after it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_INIT_CMD;
      ret_state <= ST_INIT_CMD;
      step      <= 2'd0;
      wait_cnt  <= '0;
      col       <= 4'd0;
      line      <= 1'b0;
      dirty     <= 1'b1;
    end else begin
      case (state)
        ST_INIT_CMD: begin
          if (!lcd_waitrequest) begin
            state    <= ST_GAP;
            step     <= step + 2'd1;
            wait_cnt <= '0;
            if (step == 2'd2)      ret_state <= ST_CLR_WAIT;
            else if (step == 2'd3) ret_state <= ST_IDLE;
            else                   ret_state <= ST_INIT_CMD;
          end
        end
        ST_CLR_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= ST_INIT_CMD;
          else                       wait_cnt <= wait_cnt + WAIT_ONE;
        end
        ST_IDLE: begin
          if (dirty) begin
            dirty <= 1'b0;
            line  <= 1'b0;
            col   <= 4'd0;
            state <= ST_LINE_ADDR;
          end
        end
        ST_LINE_ADDR: begin
          if (!lcd_waitrequest) begin
            state     <= ST_GAP;
            ret_state <= ST_CHAR_WR;
          end
        end
        ST_CHAR_WR: begin
          if (!lcd_waitrequest) begin
            state <= ST_GAP;
            col   <= col + 4'd1;
            if (col == 4'd15) begin
              line      <= ~line;
              ret_state <= line ? ST_IDLE : ST_LINE_ADDR;
            end else begin
              ret_state <= ST_CHAR_WR;
            end
          end
        end
        ST_GAP:  state <= ret_state;
        default: state <= ST_INIT_CMD;
      endcase
      // A new write or refresh always wins over the IDLE clear, so a
      // change landing in that cycle is never lost.
      if (wr_en || refresh) dirty <= 1'b1;
    end
  end

  // The character is captured when the data transfer starts so that the
  // byte on the bus stays stable through waitrequest stalls even if the
  // buffer is rewritten meanwhile.
  always_ff @(posedge clk) begin
    if (state == ST_GAP && ret_state == ST_CHAR_WR) char_q <= rd_data;
  end

  always_comb begin
    xfer_data = 8'h00;
    case (state)
      ST_INIT_CMD:  xfer_data = init_cmd(step);
      ST_LINE_ADDR: xfer_data = line ? CMD_LINE1 : CMD_LINE0;
      ST_CHAR_WR:   xfer_data = char_q;
      default:      xfer_data = 8'h00;
    endcase
  end

  // Gating with reset keeps the bus quiet throughout reset and lets the
  // first instruction go out in the very first cycle after release.
  assign lcd_chipselect = reset && in_xfer;
  assign lcd_write      = reset && in_xfer;
  assign lcd_address    = reset && (state == ST_CHAR_WR);
  assign lcd_writedata  = reset ? xfer_data : 8'h00;
  assign lcd_read       = 1'b0;
  assign busy           = !reset || (state != ST_IDLE) || dirty;

endmodule

// File: tb/tb_lcd_text_writer.sv
module tb_lcd_text_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       char_valid;
  logic       char_ready;
  logic [4:0] char_pos;
  logic [7:0] char_data;
  logic       refresh;
  logic       busy;
  logic       lcd_address;
  logic       lcd_chipselect;
  logic       lcd_write;
  logic       lcd_read;
  logic [7:0] lcd_writedata;
  logic       lcd_waitrequest;

  int checks = 0;
  int errors = 0;

  logic [8:0] xq [$];
  int         xh [$];
  int         xt [$];
  int         xcount = 0;
  int         cyc = 0;
  int         last_holds [34];
  logic [7:0] scr [32];

  int stall_mode = 0;
  int stall_target = 0;
  int stall_left = 0;

  lcd_text_writer #(.CLEAR_WAIT_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .char_valid      (char_valid),
    .char_ready      (char_ready),
    .char_pos        (char_pos),
    .char_data       (char_data),
    .refresh         (refresh),
    .busy            (busy),
    .lcd_address     (lcd_address),
    .lcd_chipselect  (lcd_chipselect),
    .lcd_write       (lcd_write),
    .lcd_read        (lcd_read),
    .lcd_writedata   (lcd_writedata),
    .lcd_waitrequest (lcd_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transfer monitor: logs each completed transfer and checks the bus
  // protocol (stable while stalled, idle cycle after every completion).
  logic       prev_active = 1'b0;
  logic       prev_done = 1'b0;
  logic [8:0] prev_item = '0;
  int         hold = 0;

  always @(negedge clk) begin
    logic active;
    cyc++;
    if (!reset) begin
      prev_active = 1'b0;
      prev_done   = 1'b0;
      hold        = 0;
    end else begin
      active = lcd_chipselect && lcd_write;
      if (prev_done) chk("gap_after_xfer", active, 0);
      if (active && prev_active && !prev_done)
        chk("hold_stable", {lcd_address, lcd_writedata}, prev_item);
      if (active) hold++;
      prev_done = active && !lcd_waitrequest;
      if (prev_done) begin
        xq.push_back({lcd_address, lcd_writedata});
        xh.push_back(hold);
        xt.push_back(cyc);
        xcount++;
        hold = 0;
      end
      prev_active = active;
      prev_item   = {lcd_address, lcd_writedata};
    end
  end

  // Slave waitrequest behaviour.
  initial begin
    lcd_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (stall_mode)
        1: lcd_waitrequest = ($urandom_range(0, 2) == 0);
        2: begin
          if (lcd_chipselect && lcd_write && xcount == stall_target && stall_left > 0) begin
            lcd_waitrequest = 1'b1;
            stall_left--;
          end else begin
            lcd_waitrequest = 1'b0;
          end
        end
        3:       lcd_waitrequest = 1'b1;
        default: lcd_waitrequest = 1'b0;
      endcase
    end
  end

  // Expected k-th transfer of a redraw, straight from the screen model.
  function automatic logic [8:0] exp_item(input int k);
    if (k == 0)  return {1'b0, 8'h80};
    if (k < 17)  return {1'b1, scr[k-1]};
    if (k == 17) return {1'b0, 8'hC0};
    return {1'b1, scr[k-2]};
  endfunction

  task automatic check_pass(input string tag, input int skip_k);
    if (xq.size() < 34) begin
      chk({tag, "_count"}, xq.size(), 34);
      xq.delete();
      xh.delete();
    end else begin
      for (int k = 0; k < 34; k++) begin
        logic [8:0] got;
        got = xq.pop_front();
        last_holds[k] = xh.pop_front();
        if (k != skip_k) chk($sformatf("%s_%0d", tag, k), got, exp_item(k));
      end
    end
  endtask

  task automatic check_init(input string tag);
    logic [7:0] cmds [4];
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
    if (xq.size() < 5 || xt.size() < 5) begin
      chk({tag, "_count"}, xq.size(), 38);
    end else begin
      chk({tag, "_clr_gap"}, xt[3] - xt[2], 6);
      chk({tag, "_redraw_start"}, xt[4] - xt[3], 3);
      for (int i = 0; i < 4; i++) begin
        void'(xh.pop_front());
        chk($sformatf("%s_cmd%0d", tag, i), xq.pop_front(), {1'b0, cmds[i]});
      end
    end
    xt.delete();
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_xcount(input string tag, input int target, input int max);
    int n;
    n = 0;
    while (xcount < target && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reached"}, xcount >= target, 1);
  endtask

  task automatic pulse(input logic v, input logic [4:0] p, input logic [7:0] d, input logic r);
    @(posedge clk); #1;
    char_valid = v; char_pos = p; char_data = d; refresh = r;
    @(posedge clk); #1;
    char_valid = 1'b0; refresh = 1'b0;
  endtask

  initial begin
    int base, n, first_wr;
    reset = 1'b0; char_valid = 1'b0; char_pos = '0; char_data = '0; refresh = 1'b0;
    for (int i = 0; i < 32; i++) scr[i] = 8'h20;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_ready", char_ready, 0);
    chk("rst_cs", lcd_chipselect, 0);
    chk("rst_write", lcd_write, 0);
    chk("rst_addr", lcd_address, 0);
    chk("rst_wdata", lcd_writedata, 0);
    chk("rst_read", lcd_read, 0);

    // Init sequence and first blank redraw
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("init_ready", char_ready, 1);
    wait_idle("init", 500);
    check_init("init");
    check_pass("init_pass", -1);
    chk("init_extra", xq.size(), 0);

    // Single write while idle: latency and content
    scr[17] = 8'h41;
    pulse(1'b1, 5'd17, 8'h41, 1'b0);
    n = 0; first_wr = -1;
    while (busy || n < 2) begin
      @(negedge clk);
      n++;
      if (lcd_write && first_wr < 0) first_wr = n;
      if (n > 300) break;
    end
    chk("lat_first_write", first_wr, 2);
    chk("lat_busy_cycles", n, 70);
    check_pass("pos17", -1);

    // Five-cycle stall on the third data write
    base = xcount;
    stall_target = base + 3;
    stall_left = 5;
    stall_mode = 2;
    pulse(1'b0, 5'd0, 8'h00, 1'b1);
    wait_idle("stall", 500);
    stall_mode = 0;
    chk("stall_total", xq.size(), 34);
    check_pass("stall", -1);
    chk("stall_hold", last_holds[3], 6);
    chk("stall_next_hold", last_holds[4], 1);

    // Write during a redraw forces a second full pass
    base = xcount;
    pulse(1'b0, 5'd0, 8'h00, 1'b1);
    wait_xcount("midpass", base + 11, 200);
    pulse(1'b1, 5'd0, 8'h5A, 1'b0);
    scr[0] = 8'h5A;
    wait_idle("midpass", 500);
    chk("midpass_total", xq.size(), 68);
    check_pass("midpass_p1", 1);
    check_pass("midpass_p2", -1);

    // Refresh and write in the same cycle: one pass
    scr[31] = 8'h7E;
    pulse(1'b1, 5'd31, 8'h7E, 1'b1);
    wait_idle("refwr", 500);
    chk("refwr_total", xq.size(), 34);
    check_pass("refwr", -1);

    // Randomized writes under random slave stalls
    stall_mode = 1;
    for (int it = 0; it < 6; it++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        logic [4:0] p;
        logic [7:0] d;
        logic       r;
        p = 5'($urandom_range(0, 31));
        d = 8'($urandom_range(33, 126));
        r = ($urandom_range(0, 3) == 0);
        scr[p] = d;
        pulse(1'b1, p, d, r);
      end
      wait_idle($sformatf("rnd%0d", it), 3000);
      chk($sformatf("rnd%0d_mod", it), xq.size() % 34, 0);
      while (xq.size() > 34) begin
        void'(xq.pop_front());
        void'(xh.pop_front());
      end
      check_pass($sformatf("rnd%0d", it), -1);
    end
    stall_mode = 0;

    // Reset while a redraw transfer is stalled
    stall_mode = 3;
    pulse(1'b0, 5'd0, 8'h00, 1'b1);
    n = 0;
    while (!lcd_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_seen", lcd_write, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_cs", lcd_chipselect, 0);
    chk("rstmid_write", lcd_write, 0);
    chk("rstmid_busy", busy, 1);
    chk("rstmid_ready", char_ready, 0);
    @(posedge clk); #1;
    stall_mode = 0;
    xq.delete(); xh.delete(); xt.delete();
    for (int i = 0; i < 32; i++) scr[i] = 8'h20;
    @(posedge clk); #1;
    reset = 1'b1;
    wait_idle("reinit", 500);
    check_init("reinit");
    check_pass("reinit_pass", -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
